// File: rtl/simon_pkg.sv
// Shared Simon Says screen geometry, tile colours and draw FSM state type.
package simon_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] DIM_COLOUR = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } draw_state_e;

    // Tile 0 top-left, 1 top-right, 2 bottom-left, 3 bottom-right.
    function automatic logic [7:0] tile_ox(input logic [1:0] t);
        return t[0] ? 8'd88 : 8'd56;
    endfunction

    function automatic logic [6:0] tile_oy(input logic [1:0] t);
        return t[1] ? 7'd68 : 7'd36;
    endfunction

    // Green, red, yellow, blue.
    function automatic logic [2:0] tile_lit(input logic [1:0] t);
        logic [2:0] c;
        case (t)
            2'd0:    c = 3'b010;
            2'd1:    c = 3'b100;
            2'd2:    c = 3'b110;
            default: c = 3'b001;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tile_draw_ctrl_if.sv
// Requester and VGA-adapter signals of the tile draw controller.
interface tile_draw_ctrl_if;
    logic       req_a;
    logic [1:0] tile_a;
    logic       lit_a;
    logic       ack_a;
    logic       req_b;
    logic [1:0] tile_b;
    logic       lit_b;
    logic       ack_b;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic       busy;

    modport master (
        output req_a, tile_a, lit_a, req_b, tile_b, lit_b,
        input  ack_a, ack_b, x_out, y_out, colour_out, plot, busy
    );

    modport slave (
        input  req_a, tile_a, lit_a, req_b, tile_b, lit_b,
        output ack_a, ack_b, x_out, y_out, colour_out, plot, busy
    );
endinterface

// File: rtl/tile_draw_ctrl_rr_arbiter2.sv
// Two-requester round-robin arbiter; grants are combinational, the
// last-grant pointer only moves on a granted cycle with en_i high.
module rr_arbiter2 (
    input  logic clk,
    input  logic resetn,
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic en_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);
    // 0 = A was granted last, 1 = B was granted last.
    logic last_b_q;

    assign gnt_a_o = req_a_i & (~req_b_i | last_b_q);
    assign gnt_b_o = req_b_i & (~req_a_i | ~last_b_q);

    // Remember who won; starts as B so A wins the first tie.
    always_ff @(posedge clk) begin
        if (!resetn)
            last_b_q <= 1'b1;
        else if (en_i && (gnt_a_o || gnt_b_o))
            last_b_q <= gnt_b_o;
    end
endmodule

// File: rtl/tile_draw_ctrl.sv
// Draws one whole Simon Says tile per granted request, one pixel per clock.
module tile_draw_ctrl
    import simon_pkg::*;
#(
    parameter int TILE_W = 16,
    parameter int TILE_H = 16
) (
    input  logic             clk,
    input  logic             resetn,
    tile_draw_ctrl_if.slave  bus_if
);
    localparam int CW = 6;

    draw_state_e   state_q, state_d;
    logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [CW-1:0] nx, ny;
    logic [1:0]    tile_q, tile_d;
    logic          lit_q, lit_d;
    logic          sel_b_q, sel_b_d;
    logic [7:0]    x_q, x_d;
    logic [6:0]    y_q, y_d;
    logic [2:0]    col_q, col_d;
    logic          plot_q, plot_d, busy_q, busy_d;
    logic          ack_a_q, ack_a_d, ack_b_q, ack_b_d;
    logic          gnt_a, gnt_b;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .resetn  (resetn),
        .req_a_i (bus_if.req_a),
        .req_b_i (bus_if.req_b),
        .en_i    (state_q == ST_IDLE),
        .gnt_a_o (gnt_a),
        .gnt_b_o (gnt_b)
    );

    // Next state: grant in IDLE, raster walk in DRAW, one ack cycle in DONE.
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        tile_d  = tile_q;
        lit_d   = lit_q;
        sel_b_d = sel_b_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        plot_d  = 1'b0;
        busy_d  = busy_q;
        ack_a_d = 1'b0;
        ack_b_d = 1'b0;
        nx      = cx_q;
        ny      = cy_q;
        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (gnt_a || gnt_b) begin
                    tile_d  = gnt_b ? bus_if.tile_b : bus_if.tile_a;
                    lit_d   = gnt_b ? bus_if.lit_b  : bus_if.lit_a;
                    sel_b_d = gnt_b;
                    cx_d    = '0;
                    cy_d    = '0;
                    x_d     = tile_ox(tile_d);
                    y_d     = tile_oy(tile_d);
                    col_d   = lit_d ? tile_lit(tile_d) : DIM_COLOUR;
                    plot_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (cx_q == CW'(TILE_W - 1) && cy_q == CW'(TILE_H - 1)) begin
                    ack_a_d = ~sel_b_q;
                    ack_b_d = sel_b_q;
                    state_d = ST_DONE;
                end else begin
                    if (cx_q == CW'(TILE_W - 1)) begin
                        nx = '0;
                        ny = cy_q + 1'b1;
                    end else begin
                        nx = cx_q + 1'b1;
                    end
                    cx_d   = nx;
                    cy_d   = ny;
                    // Coordinates wrap silently; no screen bounds check.
                    x_d    = tile_ox(tile_q) + 8'(nx);
                    y_d    = tile_oy(tile_q) + 7'(ny);
                    plot_d = 1'b1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any draw in progress.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            tile_q  <= '0;
            lit_q   <= 1'b0;
            sel_b_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            tile_q  <= tile_d;
            lit_q   <= lit_d;
            sel_b_q <= sel_b_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            plot_q  <= plot_d;
            busy_q  <= busy_d;
            ack_a_q <= ack_a_d;
            ack_b_q <= ack_b_d;
        end
    end

    assign bus_if.x_out      = x_q;
    assign bus_if.y_out      = y_q;
    assign bus_if.colour_out = col_q;
    assign bus_if.plot       = plot_q;
    assign bus_if.busy       = busy_q;
    assign bus_if.ack_a      = ack_a_q;
    assign bus_if.ack_b      = ack_b_q;
endmodule
